bus_mux_arbiter: RTL and testbench
==================================

// Module: bus_mux_arbiter
// PURPOSE
//  Round-robin arbiter that shares one dual 4:1 mux bus slice (sel/enable pair of a 74153) among four requesters.
//  Sequences each handover: picks the next owner, drives sel with the mux disabled, waits SETTLE_CYCLES, then grants.
//  Sits between the microsequencer's bus requesters and the 74153 select/enable pins in the 74xxx datapath model.
// PARAMETERS
//  SETTLE_CYCLES  2    clocks the mux stays disabled after sel changes (covers 34+15 ns path); legal 1..15
//  HOLD_MAX       64   max GRANT cycles before forced release (used only with ARB_TIMEOUT_EN); legal 2..255
// PORTS
//  clock     in   1  system clock, rising edge
//  notReset  in   1  asynchronous, active-low reset
//  req       in   4  request per requester, level; held until done
//  done      in   4  owner's release strobe, 1 cycle; only done[owner] is honoured
//  grant     out  4  one-hot grant; all zero when no owner
//  sel       out  2  to 74153 sel[1:0]; equals owner index
//  notIE     out  2  to 74153 notIE[1:0]; 2'b11 = outputs forced low, 2'b00 = pass
//  busy      out  1  high in SELECT, GRANT, RELEASE
//  timeout   out  1  1-cycle pulse on forced release (ARB_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (notReset low, async): state=IDLE, grant=0, sel=0, notIE=2'b11, busy=0, timeout=0, last=3.
//  All outputs registered; no combinational req->grant path.
//  Pick: first set req bit scanning last+1, last+2, ... (mod 4); index wraps 3->0.
//  IDLE: notIE=11, grant=0, sel holds. Any req set at edge k -> SELECT after k; sel=pick, cnt=SETTLE_CYCLES-1.
//  SELECT: notIE=11, grant=0. cnt==0 at edge -> GRANT; else cnt--. grant[owner] and notIE=00 both
//   rise after edge k+SETTLE_CYCLES (req-to-grant latency SETTLE_CYCLES+1 edges incl. sampling edge).
//   req[owner] low in SELECT -> IDLE next edge, last unchanged, no grant issued.
//  GRANT: notIE=00, grant[owner]=1. done[owner] or req[owner] low -> RELEASE. done on other indices ignored.
//  RELEASE: grant=0, notIE=11 in same cycle (mux disabled before sel may move); last=owner; -> IDLE next edge.
//   Minimum owner-to-owner gap: RELEASE + IDLE + SELECT(SETTLE_CYCLES) cycles; back-to-back owners never overlap.
//  New req bits arriving in SELECT/GRANT/RELEASE do not preempt; they enter the next IDLE pick.
//  done and req-drop in the same cycle: single RELEASE, no double count.
//  notReset low mid-GRANT: grant and notIE drop asynchronously to reset values; last returns to 3.
//  Invariant: popcount(grant)<=1; grant!=0 implies notIE==00 and sel==index(grant).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: hold counter cleared on GRANT entry, increments each GRANT cycle; at HOLD_MAX
//   cycles without release -> RELEASE, timeout=1 for that cycle, last=owner (owner loses turn).
//  ARB_TIMEOUT_EN undefined: no hold counter; GRANT persists until done/req-drop; timeout tied 0; HOLD_MAX unused.
// STRUCTURE
//  Shared include bus_mux_arb_defs.v (`ifndef guarded): state encodings ARB_IDLE=2'd0, ARB_SELECT=2'd1,
//   ARB_GRANT=2'd2, ARB_RELEASE=2'd3; requester count constant ARB_N=4.
//  Sub-module rr_pick4: combinational (req[3:0], last[1:0]) -> (valid, idx[1:0]); instanced once.
//  Top holds FSM, settle counter, optional hold counter, output registers.
// TESTING
//  Single req: req=4'b0100 from reset, SETTLE_CYCLES=2 -> sel=2 after edge 1, grant=4'b0100, notIE=00 after edge 3.
//  All req=4'b1111 held, each done after 1 GRANT cycle -> grant order 0,1,2,3,0; notIE=11 in every gap.
//  Cancel: req=4'b0010 dropped during SELECT -> back to IDLE, grant never asserts, next pick still starts at 0.
//  Stray done: owner 1 granted, done=4'b0100 pulsed -> grant stays 4'b0010; done=4'b0010 -> RELEASE next edge.
//  Async reset mid-GRANT: notReset low between edges -> grant=0, notIE=11, sel=0 immediately, not at next edge.
//  ARB_TIMEOUT_EN, HOLD_MAX=4: owner 0 never signals done -> release after 4 GRANT cycles, timeout pulses once, owner 1 next.

Source files
------------

// File: rtl/bus_mux_arbiter_pkg.sv
// Shared types and constants for the 74153 bus-slice round-robin arbiter.
package bus_mux_arbiter_pkg;

    localparam int ARB_N = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SELECT  = 2'd1,
        ARB_GRANT   = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    function automatic logic [ARB_N-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_mux_arbiter_if.sv
// Requester/mux-pin bundle; the arbiter takes the master view, requesters the slave view.
interface bus_mux_arbiter_if;
    import bus_mux_arbiter_pkg::*;

    logic [ARB_N-1:0] req;
    logic [ARB_N-1:0] done;
    logic [ARB_N-1:0] grant;
    logic [1:0]       sel;
    logic [1:0]       notIE;
    logic             busy;
    logic             timeout;

    modport master (
        input  req, done,
        output grant, sel, notIE, busy, timeout
    );

    modport slave (
        output req, done,
        input  grant, sel, notIE, busy, timeout
    );
endinterface

// File: rtl/bus_mux_arbiter_rr_pick4.sv
// Round-robin picker: first set req bit scanning last+1, last+2, ... (mod 4).
module rr_pick4
    import bus_mux_arbiter_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic [1:0]       last,
    output logic             valid,
    output logic [1:0]       idx
);
    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        for (int i = ARB_N; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                valid = 1'b1;
                idx   = last + 2'(i);
            end
        end
    end
endmodule

// File: rtl/bus_mux_arbiter.sv
// Round-robin owner of one 74153 sel/enable pair with settle delay before grant.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module bus_mux_arbiter
    import bus_mux_arbiter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_MAX      = 64
) (
    input  logic             clock,
    input  logic             notReset,
    bus_mux_arbiter_if.master bus
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_params
        $error("bus_mux_arbiter: SETTLE_CYCLES or HOLD_MAX out of range");
    end

    arb_state_e       state_q;
    logic [ARB_N-1:0] grant_q;
    logic [1:0]       sel_q;
    logic [1:0]       notIE_q;
    logic             busy_q;
    logic [1:0]       last_q;
    logic [3:0]       cnt_q;
    logic             pick_valid_d;
    logic [1:0]       pick_idx_d;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]       hold_q;
    logic             timeout_q;
`endif

    rr_pick4 u_pick (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid_d),
        .idx   (pick_idx_d)
    );

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            sel_q     <= 2'd0;
            notIE_q   <= 2'b11;
            busy_q    <= 1'b0;
            last_q    <= 2'd3;
            cnt_q     <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid_d) begin
                        state_q <= ARB_SELECT;
                        sel_q   <= pick_idx_d;
                        cnt_q   <= 4'(SETTLE_CYCLES - 1);
                        busy_q  <= 1'b1;
                    end
                end
                ARB_SELECT: begin
                    // A requester that gives up while the mux settles forfeits without costing a turn.
                    if (!bus.req[sel_q]) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= ARB_GRANT;
                        grant_q <= onehot4(sel_q);
                        notIE_q <= 2'b00;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= 8'd0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ARB_GRANT: begin
                    // grant and notIE fall together so the mux is off before sel can move.
                    if (bus.done[sel_q] || !bus.req[sel_q]) begin
                        state_q <= ARB_RELEASE;
                        grant_q <= '0;
                        notIE_q <= 2'b11;
                        last_q  <= sel_q;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_q == 8'(HOLD_MAX - 1)) begin
                        state_q   <= ARB_RELEASE;
                        grant_q   <= '0;
                        notIE_q   <= 2'b11;
                        last_q    <= sel_q;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 8'd1;
`endif
                    end
                end
                ARB_RELEASE: begin
                    state_q <= ARB_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.notIE = notIE_q;
    assign bus.busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Scoreboard bench for bus_mux_arbiter: expected grant owners queued by stimulus, popped by a monitor.
module tb_bus_mux_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];

    bus_mux_arbiter_if bus_if ();

    bus_mux_arbiter #(.SETTLE_CYCLES(2), .HOLD_MAX(4)) dut (
        .clock    (clk),
        .notReset (rst_n),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (bus_if.grant == 4'b0 && n < 30) begin
            tick();
            n++;
        end
        if (bus_if.grant == 4'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: no grant within 30 cycles (got %0h)", name, bus_if.grant);
        end
    endtask

    task automatic do_reset();
        bus_if.req  = 4'b0;
        bus_if.done = 4'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: invariants every cycle, and each fresh grant is matched to the scoreboard.
    logic [3:0] prev_grant = 4'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.grant == 4'b0) begin
                chk("mux off while ungranted", 32'(bus_if.notIE), 32'h3);
            end else begin
                chk("grant onehot", 32'($countones(bus_if.grant)), 32'd1);
                chk("mux on while granted", 32'(bus_if.notIE), 32'h0);
                chk("grant matches sel", 32'(bus_if.grant), 32'(1) << bus_if.sel);
            end
            if (bus_if.grant != 4'b0 && prev_grant == 4'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected grant: got %0h expected none", bus_if.grant);
                end else begin
                    int o;
                    o = exp_q.pop_front();
                    chk("grant owner", 32'(bus_if.grant), 32'(1) << o);
                end
            end
        end
        prev_grant = bus_if.grant;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.req  = 4'b0;
        bus_if.done = 4'b0;
        #12;
        chk("reset grant", 32'(bus_if.grant), 32'h0);
        chk("reset sel", 32'(bus_if.sel), 32'h0);
        chk("reset notIE", 32'(bus_if.notIE), 32'h3);
        chk("reset busy", 32'(bus_if.busy), 32'h0);
        chk("reset timeout", 32'(bus_if.timeout), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request, settle latency
        bus_if.req = 4'b0100;
        exp_q.push_back(2);
        tick();
        chk("single sel after edge1", 32'(bus_if.sel), 32'h2);
        chk("single busy in select", 32'(bus_if.busy), 32'h1);
        chk("single no grant edge1", 32'(bus_if.grant), 32'h0);
        tick();
        chk("single no grant edge2", 32'(bus_if.grant), 32'h0);
        chk("single notIE edge2", 32'(bus_if.notIE), 32'h3);
        tick();
        chk("single grant edge3", 32'(bus_if.grant), 32'h4);
        chk("single notIE edge3", 32'(bus_if.notIE), 32'h0);
        bus_if.req = 4'b0;
        tick();
        chk("single release grant", 32'(bus_if.grant), 32'h0);
        chk("single release busy", 32'(bus_if.busy), 32'h1);
        tick();
        chk("single idle busy", 32'(bus_if.busy), 32'h0);

        // All requesting, one GRANT cycle each
        do_reset();
        bus_if.req = 4'b1111;
        foreach (exp_q[i]) ;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int i = 0; i < 5; i++) begin
            wait_grant("rr wait");
            bus_if.done = bus_if.grant;
            tick();
            bus_if.done = 4'b0;
            chk("rr gap notIE", 32'(bus_if.notIE), 32'h3);
        end
        bus_if.req = 4'b0;
        tick();
        tick();

        // Cancel during SELECT
        do_reset();
        bus_if.req = 4'b0010;
        tick();
        chk("cancel sel", 32'(bus_if.sel), 32'h1);
        chk("cancel busy select", 32'(bus_if.busy), 32'h1);
        bus_if.req = 4'b0;
        tick();
        chk("cancel back to idle", 32'(bus_if.busy), 32'h0);
        tick(); tick(); tick();
        chk("cancel never granted", 32'(bus_if.grant), 32'h0);
        bus_if.req = 4'b0011;
        exp_q.push_back(0);
        wait_grant("cancel next");
        chk("cancel next pick 0", 32'(bus_if.grant), 32'h1);
        bus_if.done = 4'b0001;
        tick();
        bus_if.done = 4'b0;
        bus_if.req  = 4'b0;
        tick(); tick();

        // Stray done on a non-owner index
        bus_if.req = 4'b0010;
        exp_q.push_back(1);
        wait_grant("stray wait");
        bus_if.done = 4'b0100;
        tick();
        bus_if.done = 4'b0;
        chk("stray done ignored", 32'(bus_if.grant), 32'h2);
        bus_if.done = 4'b0010;
        tick();
        bus_if.done = 4'b0;
        chk("owner done releases", 32'(bus_if.grant), 32'h0);
        chk("owner done busy", 32'(bus_if.busy), 32'h1);
        bus_if.req = 4'b0;
        tick(); tick();

        // Async reset mid-GRANT (last=1, so requester 3 wins)
        bus_if.req = 4'b1000;
        exp_q.push_back(3);
        wait_grant("async wait");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async grant", 32'(bus_if.grant), 32'h0);
        chk("async notIE", 32'(bus_if.notIE), 32'h3);
        chk("async sel", 32'(bus_if.sel), 32'h0);
        chk("async busy", 32'(bus_if.busy), 32'h0);
        bus_if.req = 4'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // done and req-drop together: one release, no regrant
        bus_if.req = 4'b0100;
        exp_q.push_back(2);
        wait_grant("both wait");
        bus_if.done = 4'b0100;
        bus_if.req  = 4'b0;
        tick();
        bus_if.done = 4'b0;
        chk("both release grant", 32'(bus_if.grant), 32'h0);
        chk("both release busy", 32'(bus_if.busy), 32'h1);
        tick();
        chk("both idle busy", 32'(bus_if.busy), 32'h0);
        tick(); tick();
        chk("both no regrant", 32'(bus_if.grant), 32'h0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after HOLD_MAX=4 grant cycles
        do_reset();
        bus_if.req = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        wait_grant("timeout wait");
        chk("timeout owner 0", 32'(bus_if.grant), 32'h1);
        tick(); tick(); tick();
        chk("timeout still held", 32'(bus_if.grant), 32'h1);
        chk("timeout not yet", 32'(bus_if.timeout), 32'h0);
        tick();
        chk("timeout released", 32'(bus_if.grant), 32'h0);
        chk("timeout pulse", 32'(bus_if.timeout), 32'h1);
        tick();
        chk("timeout one cycle", 32'(bus_if.timeout), 32'h0);
        wait_grant("timeout next");
        chk("timeout next owner 1", 32'(bus_if.grant), 32'h2);
        bus_if.done = 4'b0010;
        bus_if.req  = 4'b0;
        tick();
        bus_if.done = 4'b0;
        tick(); tick();
`else
        chk("timeout tied low", 32'(bus_if.timeout), 32'h0);
`endif

        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
